// File: rtl/isdu_pkg.sv
// isdu_pkg: state codes, opcodes and datapath mux encodings shared by the
// LC-3 instruction sequencer/decoder (isdu_param) and its wait timer.
package isdu_pkg;

  // State register encoding (legacy-compatible constant style)
  localparam int ST_W = 5;
  typedef logic [ST_W-1:0] state_t;

  localparam logic [4:0] S_HALTED   = 5'd0;
  localparam logic [4:0] S_FETCH    = 5'd1;
  localparam logic [4:0] S_RD_WAIT  = 5'd2;
  localparam logic [4:0] S_IR_LOAD  = 5'd3;
  localparam logic [4:0] S_DECODE   = 5'd4;
  localparam logic [4:0] S_ADD      = 5'd5;
  localparam logic [4:0] S_AND      = 5'd6;
  localparam logic [4:0] S_NOT      = 5'd7;
  localparam logic [4:0] S_BR       = 5'd8;
  localparam logic [4:0] S_BR_TAKEN = 5'd9;
  localparam logic [4:0] S_JMP      = 5'd10;
  localparam logic [4:0] S_JSR      = 5'd11;
  localparam logic [4:0] S_JSR_TGT  = 5'd12;
  localparam logic [4:0] S_LDR      = 5'd13;
  localparam logic [4:0] S_LD_WAIT  = 5'd14;
  localparam logic [4:0] S_LD_WB    = 5'd15;
  localparam logic [4:0] S_STR      = 5'd16;
  localparam logic [4:0] S_ST_DATA  = 5'd17;
  localparam logic [4:0] S_ST_WAIT  = 5'd18;
  localparam logic [4:0] S_PAUSE1   = 5'd19;
  localparam logic [4:0] S_PAUSE2   = 5'd20;

  // IR[15:12] opcodes
  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  // PCMUX select
  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_ADDR = 2'b01;
  localparam logic [1:0] PCMUX_BUS  = 2'b10;

  // ADDR2MUX select
  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  // ALU function
  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage

// File: rtl/isdu_wait_timer.sv
// isdu_wait_timer: shared SRAM wait counter. Loads on a strobe, counts down
// to zero and holds there; Done is high while the count is zero.
module isdu_wait_timer #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic [W-1:0] Load_Value,
  output logic [W-1:0] Count,
  output logic         Done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg;

  // Load has priority; otherwise decrement until zero
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      count_reg <= '0;
    else if (Load)
      count_reg <= Load_Value;
    else if (count_reg != '0)
      count_reg <= count_reg - ONE;
  end

  assign Count = count_reg;
  assign Done  = (count_reg == '0);

endmodule

// File: rtl/isdu_param.sv
// isdu_param: parametrised LC-3 instruction sequencer/decoder.
// Optional PAUSE1/PAUSE2 handshake states are built only when the macro
// ISDU_PAUSE_EN is defined; otherwise opcode 1101 decodes as unknown.
// The first wait after an address is formed from MARMUX (LD_WAIT, ST_WAIT)
// spends one leading cycle with the strobe inactive so the address settles
// before OE/WE fall; instruction fetch (RD_WAIT) has no such cycle.
module isdu_param
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Continue,
  input  logic [3:0]       Opcode,
  input  logic             IR_5,
  input  logic             IR_11,
  input  logic             BEN,
  output logic             LD_MAR,
  output logic             LD_MDR,
  output logic             LD_IR,
  output logic             LD_BEN,
  output logic             LD_CC,
  output logic             LD_REG,
  output logic             LD_PC,
  output logic             LD_LED,
  output logic             GatePC,
  output logic             GateMDR,
  output logic             GateALU,
  output logic             GateMARMUX,
  output logic [1:0]       PCMUX,
  output logic             DRMUX,
  output logic             SR1MUX,
  output logic             SR2MUX,
  output logic             ADDR1MUX,
  output logic [1:0]       ADDR2MUX,
  output logic [1:0]       ALUK,
  output logic             Mem_CE,
  output logic             Mem_UB,
  output logic             Mem_LB,
  output logic             Mem_OE,
  output logic             Mem_WE,
  output logic             Busy,
  output logic [CNT_W-1:0] Instr_Count
);

  localparam int TW = $clog2(MEM_WAIT + 2);
  // Load values: the state lasts (load value + 1) cycles
  localparam logic [TW-1:0] RD_LOAD = TW'(MEM_WAIT - 1);
  localparam logic [TW-1:0] LD_LOAD = TW'(MEM_WAIT);
  localparam logic [TW-1:0] ST_LOAD = TW'(MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] instr_count_reg;
  logic             timer_load;
  logic [TW-1:0]    timer_value;
  logic [TW-1:0]    timer_count;
  logic             timer_done;

  isdu_wait_timer #(.W(TW)) u_wait_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load       (timer_load),
    .Load_Value (timer_value),
    .Count      (timer_count),
    .Done       (timer_done)
  );

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state_reg <= S_HALTED;
    else
      state_reg <= state_next;
  end

  // Retired-instruction counter: every exit from DECODE counts
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      instr_count_reg <= '0;
    else if (state_reg == S_DECODE)
      instr_count_reg <= instr_count_reg + CNT_ONE;
  end

  // Timer is loaded on the edge that enters a wait state
  always_comb begin
    timer_load  = 1'b0;
    timer_value = RD_LOAD;
    case (state_reg)
      S_FETCH:   begin timer_load = 1'b1; timer_value = RD_LOAD; end
      S_LDR:     begin timer_load = 1'b1; timer_value = LD_LOAD; end
      S_ST_DATA: begin timer_load = 1'b1; timer_value = ST_LOAD; end
      default:   ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_HALTED:   if (Run) state_next = S_FETCH;
      S_FETCH:    state_next = S_RD_WAIT;
      S_RD_WAIT:  if (timer_done) state_next = S_IR_LOAD;
      S_IR_LOAD:  state_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD:   state_next = S_ADD;
          OP_AND:   state_next = S_AND;
          OP_NOT:   state_next = S_NOT;
          OP_BR:    state_next = S_BR;
          OP_JMP:   state_next = S_JMP;
          OP_JSR:   state_next = S_JSR;
          OP_LDR:   state_next = S_LDR;
          OP_STR:   state_next = S_STR;
`ifdef ISDU_PAUSE_EN
          OP_PAUSE: state_next = S_PAUSE1;
`endif
          default:  state_next = S_FETCH;
        endcase
      end
      S_BR:       state_next = BEN ? S_BR_TAKEN : S_FETCH;
      S_JSR:      state_next = S_JSR_TGT;
      S_LDR:      state_next = S_LD_WAIT;
      S_LD_WAIT:  if (timer_done) state_next = S_LD_WB;
      S_STR:      state_next = S_ST_DATA;
      S_ST_DATA:  state_next = S_ST_WAIT;
      S_ST_WAIT:  if (timer_done) state_next = S_FETCH;
`ifdef ISDU_PAUSE_EN
      S_PAUSE1:   if (Continue) state_next = S_PAUSE2;
      S_PAUSE2:   if (!Continue) state_next = S_FETCH;
`endif
      default:    state_next = S_FETCH;
    endcase
  end

  // Datapath controls, decoded from the registered state only
  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_PC1; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_ADD;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state_reg)
      S_FETCH:    begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_PC1; end
      S_RD_WAIT:  begin Mem_OE = 1'b0; LD_MDR = timer_done; end
      S_IR_LOAD:  begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_DECODE:   LD_BEN = 1'b1;
      S_ADD:      begin SR2MUX = IR_5; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = ALUK_ADD; end
      S_AND:      begin SR2MUX = IR_5; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = ALUK_AND; end
      S_NOT:      begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = ALUK_NOT; end
      S_BR_TAKEN: begin ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDR; LD_PC = 1'b1; end
      S_JMP:      begin ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_ZERO; PCMUX = PCMUX_ADDR; LD_PC = 1'b1; end
      S_JSR:      begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S_JSR_TGT: begin
        LD_PC = 1'b1;
        PCMUX = PCMUX_ADDR;
        ADDR1MUX = !IR_11;
        ADDR2MUX = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
      end
      S_LDR, S_STR: begin ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6; GateMARMUX = 1'b1; LD_MAR = 1'b1; end
      // Leading cycle (count still at load value) keeps OE high
      S_LD_WAIT:  begin Mem_OE = (timer_count == LD_LOAD); LD_MDR = timer_done; end
      S_LD_WB:    begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_ST_DATA:  begin SR1MUX = 1'b1; ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1; end
      // Leading cycle keeps WE high; WE then low for MEM_WAIT+1 cycles
      S_ST_WAIT:  Mem_WE = (timer_count == ST_LOAD);
`ifdef ISDU_PAUSE_EN
      S_PAUSE1, S_PAUSE2: LD_LED = 1'b1;
`endif
      default:    ;
    endcase
  end

`ifndef ISDU_PAUSE_EN
  // Continue only matters for the pause handshake
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  assign Mem_CE      = 1'b0;
  assign Mem_UB      = 1'b0;
  assign Mem_LB      = 1'b0;
  assign Busy        = (state_reg != S_HALTED);
  assign Instr_Count = instr_count_reg;

endmodule

// File: tb/tb_isdu_param.sv
// tb_isdu_param: scoreboard bench for isdu_param (MEM_WAIT=4, CNT_W=4).
// Stimulus pushes one expected record per instruction; a monitor measures
// each FETCH-to-FETCH window and compares against the popped record.
module tb_isdu_param;

  localparam int MW = 4;
  localparam int CW = 4;

  logic          Clk, Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0]    Opcode;
  logic          LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic          GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]    PCMUX, ADDR2MUX, ALUK;
  logic          DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic          Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Busy;
  logic [CW-1:0] Instr_Count;

  isdu_param #(.MEM_WAIT(MW), .CNT_W(CW)) u_dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Busy(Busy), .Instr_Count(Instr_Count)
  );

  typedef struct {
    string name;
    int op, ir5, ir11, ben;
    int cyc, oe, we, regcc, aluk, imm, pcn, pcc, drm, led, cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  logic [24:0] ctl_vec;
  assign ctl_vec = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                    GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                    SR2MUX, ADDR1MUX, ADDR2MUX, ALUK, Mem_CE, Mem_UB, Mem_LB};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string name, input int op, ir5, ir11, ben,
                              cyc, oe, we, regcc, aluk, imm, pcn, pcc, drm, led);
    exp_t e;
    e.name = name; e.op = op; e.ir5 = ir5; e.ir11 = ir11; e.ben = ben;
    e.cyc = cyc; e.oe = oe; e.we = we; e.regcc = regcc; e.aluk = aluk;
    e.imm = imm; e.pcn = pcn; e.pcc = pcc; e.drm = drm; e.led = led; e.cnt = 0;
    return e;
  endfunction

  // Monitor: one record per FETCH-to-FETCH window
  initial begin : monitor
    bit   active;
    int   a_cyc, a_oe, a_we, a_run, a_run_max, a_regcc, a_aluk, a_imm;
    int   a_pcn, a_pcc, a_drm, a_led, a_bad, gates;
    exp_t e;
    active = 0;
    a_cyc = 0; a_oe = 0; a_we = 0; a_run = 0; a_run_max = 0; a_regcc = 0;
    a_aluk = 0; a_imm = 0; a_pcn = 0; a_pcc = 0; a_drm = 0; a_led = 0; a_bad = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        active = 0;
      end else begin
        if (GatePC && LD_MAR) begin
          if (active) begin
            if (exp_q.size() == 0) begin
              check("unexpected_txn", 1, 0);
            end else begin
              e = exp_q.pop_front();
              $display("txn %s: cycles=%0d oe_low=%0d we_low=%0d led=%0d count=%0d",
                       e.name, a_cyc, a_oe, a_we, a_led, Instr_Count);
              check({e.name, "_cycles"}, a_cyc, e.cyc);
              check({e.name, "_oe_low"}, a_oe, e.oe);
              check({e.name, "_we_low"}, a_we, e.we);
              check({e.name, "_we_run"}, a_run_max, e.we);
              check({e.name, "_regcc_cycle"}, a_regcc, e.regcc);
              check({e.name, "_aluk"}, a_aluk, e.aluk);
              check({e.name, "_sr2mux"}, a_imm, e.imm);
              check({e.name, "_pc_addr_loads"}, a_pcn, e.pcn);
              check({e.name, "_addr_mux"}, a_pcc, e.pcc);
              check({e.name, "_drmux"}, a_drm, e.drm);
              check({e.name, "_ld_led"}, a_led, e.led);
              check({e.name, "_bus_conflict"}, a_bad, 0);
              check({e.name, "_instr_count"}, int'(Instr_Count), e.cnt);
            end
          end
          active = 1;
          a_cyc = 0; a_oe = 0; a_we = 0; a_run = 0; a_run_max = 0; a_regcc = 0;
          a_aluk = 0; a_imm = 0; a_pcn = 0; a_pcc = 0; a_drm = 0; a_led = 0; a_bad = 0;
        end
        if (active) begin
          a_cyc++;
          if (!Mem_OE) a_oe++;
          if (!Mem_WE) begin
            a_we++; a_run++;
            if (a_run > a_run_max) a_run_max = a_run;
          end else begin
            a_run = 0;
          end
          if (LD_REG && LD_CC && a_regcc == 0) begin
            a_regcc = a_cyc; a_aluk = int'(ALUK);
          end
          if (LD_PC && PCMUX == 2'b01) begin
            a_pcn++; a_pcc = int'({ADDR1MUX, ADDR2MUX});
          end
          if (SR2MUX) a_imm++;
          if (DRMUX && LD_REG) a_drm++;
          if (LD_LED) a_led++;
          gates = int'(GatePC) + int'(GateMDR) + int'(GateALU) + int'(GateMARMUX);
          if (gates > 1 || (!Mem_OE && !Mem_WE)) a_bad++;
        end
      end
    end
  end

  task automatic wait_fetch(input string what);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge Clk);
      if (GatePC && LD_MAR) seen = 1;
    end
    check({what, "_fetch_reached"}, int'(seen), 1);
  endtask

  // Called at the negedge of a FETCH cycle; returns at the next FETCH
  task automatic issue(input exp_t x);
    Opcode = x.op[3:0]; IR_5 = x.ir5[0]; IR_11 = x.ir11[0]; BEN = x.ben[0];
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    x.cnt = exp_cnt;
    exp_q.push_back(x);
`ifdef ISDU_PAUSE_EN
    if (x.op == 13) begin
      repeat (17) @(negedge Clk);
      Continue = 1'b1;
      repeat (2) @(negedge Clk);
      Continue = 1'b0;
    end
`endif
    wait_fetch(x.name);
  endtask

  initial begin : stimulus
    bit seen;
    Reset = 1'b0; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'd0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    #1 Reset = 1'b1;
    #2;
    check("reset_controls", int'(ctl_vec), 0);
    check("reset_mem_oe", int'(Mem_OE), 1);
    check("reset_mem_we", int'(Mem_WE), 1);
    check("reset_busy", int'(Busy), 0);
    check("reset_count", int'(Instr_Count), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("halted_without_run", int'(Busy), 0);

    Run = 1'b1;
    wait_fetch("run");
    Run = 1'b0;
    check("busy_after_run", int'(Busy), 1);

    //           name     op ir5 ir11 ben cyc oe we regcc aluk imm pcn pcc drm led
    issue(mk("add",     1, 1, 0, 0,   8, 4, 0,   8, 0, 1, 0, 0, 0, 0));
    issue(mk("and",     5, 0, 0, 0,   8, 4, 0,   8, 1, 0, 0, 0, 0, 0));
    issue(mk("not",     9, 0, 0, 0,   8, 4, 0,   8, 2, 0, 0, 0, 0, 0));
    issue(mk("br_nt",   0, 0, 0, 0,   8, 4, 0,   0, 0, 0, 0, 0, 0, 0));
    issue(mk("br_t",    0, 0, 0, 1,   9, 4, 0,   0, 0, 0, 1, 2, 0, 0));
    issue(mk("jmp",    12, 0, 0, 0,   8, 4, 0,   0, 0, 0, 1, 4, 0, 0));
    issue(mk("jsr",     4, 0, 1, 0,   9, 4, 0,   0, 0, 0, 1, 3, 1, 0));
    issue(mk("jsrr",    4, 0, 0, 0,   9, 4, 0,   0, 0, 0, 1, 4, 1, 0));
    issue(mk("ldr",     6, 0, 0, 0,  14, 8, 0,  14, 0, 0, 0, 0, 0, 0));
    issue(mk("str",     7, 0, 0, 0,  15, 4, 5,   0, 0, 0, 0, 0, 0, 0));
    issue(mk("op1111", 15, 0, 0, 0,   7, 4, 0,   0, 0, 0, 0, 0, 0, 0));
`ifdef ISDU_PAUSE_EN
    issue(mk("pause",  13, 0, 0, 0,  20, 4, 0,   0, 0, 0, 0, 0, 0, 13));
`else
    issue(mk("op1101", 13, 0, 0, 0,   7, 4, 0,   0, 0, 0, 0, 0, 0, 0));
`endif

    // Store interrupted by reset during its second ST_WAIT cycle
    Opcode = 4'b0111;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (!Mem_WE) seen = 1;
    end
    check("store_we_reached", int'(seen), 1);
    check("count_before_reset", int'(Instr_Count), (exp_cnt + 1) % (1 << CW));
    Reset = 1'b1;
    #1;
    check("midwrite_reset_we", int'(Mem_WE), 1);
    check("midwrite_reset_oe", int'(Mem_OE), 1);
    check("midwrite_reset_busy", int'(Busy), 0);
    check("midwrite_reset_count", int'(Instr_Count), 0);
    check("midwrite_reset_controls", int'(ctl_vec), 0);
    exp_cnt = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Run = 1'b1;
    wait_fetch("rerun");
    Run = 1'b0;

    // Sixteen NOTs wrap the 4-bit counter back to zero
    for (int n = 0; n < 16; n++)
      issue(mk($sformatf("not_%0d", n), 9, 0, 0, 0, 8, 4, 0, 8, 2, 0, 0, 0, 0, 0));

    @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);
    check("count_wrapped", int'(Instr_Count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
